// File: rtl/mem_access_scheduler.sv
// mem_access_scheduler: sequences the single-port data memory between load/store buffers and the CDB.
// Optional MSCHED_STARVE_GUARD_EN: stores take priority after STARVE_MAX blocked cycles.
module mem_access_scheduler #(
  parameter int NUM_LD     = 2,
  parameter int NUM_ST     = 2,
  parameter int TAG_W      = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_LD-1:0]        ld_req,
  input  logic [NUM_LD*ADDR_W-1:0] ld_addr,
  input  logic [NUM_LD*TAG_W-1:0]  ld_tag,
  output logic [NUM_LD-1:0]        ld_grant,
  input  logic [NUM_ST-1:0]        st_req,
  input  logic [NUM_ST*ADDR_W-1:0] st_addr,
  input  logic [NUM_ST*DATA_W-1:0] st_data,
  output logic [NUM_ST-1:0]        st_grant,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     cdb_req,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  input  logic                     cdb_grant
);

  logic              res_valid_q, res_valid_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;

  logic [NUM_LD-1:0] ld_sel;
  logic [NUM_ST-1:0] st_sel;
  logic [ADDR_W-1:0] ld_a, st_a;
  logic [TAG_W-1:0]  ld_t;
  logic [DATA_W-1:0] st_d;
  logic              ld_elig, st_elig;
  logic              st_first;
  logic              take_ld, take_st;

  // lowest set bit isolates the winning index
  assign ld_sel = ld_req & (~ld_req + NUM_LD'(1));
  assign st_sel = st_req & (~st_req + NUM_ST'(1));

  always_comb begin
    ld_a = '0;
    ld_t = '0;
    for (int i = 0; i < NUM_LD; i++) begin
      if (ld_sel[i]) begin
        ld_a = ld_addr[i*ADDR_W +: ADDR_W];
        ld_t = ld_tag[i*TAG_W +: TAG_W];
      end
    end
    st_a = '0;
    st_d = '0;
    for (int i = 0; i < NUM_ST; i++) begin
      if (st_sel[i]) begin
        st_a = st_addr[i*ADDR_W +: ADDR_W];
        st_d = st_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ld_elig = (|ld_req) && (!res_valid_q || cdb_grant);
  assign st_elig = |st_req;
  assign take_ld = ld_elig && !(st_first && st_elig);
  assign take_st = st_elig && !take_ld;

`ifdef MSCHED_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  assign st_first = (starve_cnt_q == CW'(STARVE_MAX));

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!st_elig || take_st)
      starve_cnt_d = '0;
    else if (!st_first)
      starve_cnt_d = starve_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end
`else
  assign st_first = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_tag_q   <= res_tag_d;
      res_data_q  <= res_data_d;
    end
  end

  // a load reloads the holding register even while it is being drained
  always_comb begin
    res_valid_d = res_valid_q;
    res_tag_d   = res_tag_q;
    res_data_d  = res_data_q;
    if (take_ld) begin
      res_valid_d = 1'b1;
      res_tag_d   = ld_t;
      res_data_d  = mem_rdata;
    end else if (cdb_grant) begin
      res_valid_d = 1'b0;
    end
  end

  always_comb begin
    ld_grant  = take_ld ? ld_sel : '0;
    st_grant  = take_st ? st_sel : '0;
    mem_we    = take_st;
    mem_addr  = '0;
    mem_wdata = '0;
    if (take_ld) begin
      mem_addr = ld_a;
    end else if (take_st) begin
      mem_addr  = st_a;
      mem_wdata = st_d;
    end
  end

  assign cdb_req  = res_valid_q;
  assign cdb_tag  = res_tag_q;
  assign cdb_data = res_data_q;

endmodule

// File: tb/tb_mem_access_scheduler.sv
// tb_mem_access_scheduler: directed scenarios plus randomized traffic
// against a behavioural scheduler/memory model.
module tb_mem_access_scheduler;
  localparam int NL = 2;
  localparam int NS = 2;
  localparam int TW = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NL-1:0]    ld_req;
  logic [NL*AW-1:0] ld_addr;
  logic [NL*TW-1:0] ld_tag;
  logic [NL-1:0]    ld_grant;
  logic [NS-1:0]    st_req;
  logic [NS*AW-1:0] st_addr;
  logic [NS*DW-1:0] st_data;
  logic [NS-1:0]    st_grant;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;
  logic             cdb_req;
  logic [TW-1:0]    cdb_tag;
  logic [DW-1:0]    cdb_data;
  logic             cdb_grant;

  mem_access_scheduler #(
    .NUM_LD(NL), .NUM_ST(NS), .TAG_W(TW),
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_tag(ld_tag), .ld_grant(ld_grant),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_grant(st_grant),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cdb_req(cdb_req), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_grant(cdb_grant)
  );

  always #5 clk = ~clk;

  // environment data memory: combinational read, write at posedge
  logic [DW-1:0] mem [0:255];
  logic          pre_we;
  logic [7:0]    pre_a;
  logic [DW-1:0] pre_d;
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_we)      mem[mem_addr[7:0]] <= mem_wdata;
    else if (pre_we) mem[pre_a] <= pre_d;
  end

  // reference model state
  logic [DW-1:0] ref_mem [0:255];
  bit            m_valid;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_data;
  int            m_starve;
  int            e_ldi, e_sti;
  logic [NL-1:0] e_ldg;
  logic [NS-1:0] e_stg;
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  int n_cmp = 0;
  int n_err = 0;

  task automatic model_reset();
    m_valid  = 0;
    m_tag    = '0;
    m_data   = '0;
    m_starve = 0;
  endtask

  task automatic model_eval();
    bit ld_ok, st_any, st_pri;
    e_ldi = -1;
    e_sti = -1;
    ld_ok  = (ld_req != 0) && (!m_valid || cdb_grant);
    st_any = (st_req != 0);
    st_pri = 0;
`ifdef MSCHED_STARVE_GUARD_EN
    st_pri = (m_starve >= SM);
`endif
    if (ld_ok && !(st_pri && st_any)) begin
      for (int i = NL - 1; i >= 0; i--) if (ld_req[i]) e_ldi = i;
    end else if (st_any) begin
      for (int i = NS - 1; i >= 0; i--) if (st_req[i]) e_sti = i;
    end
    e_ldg = '0; e_stg = '0; e_we = 0; e_addr = '0; e_wdata = '0;
    if (e_ldi >= 0) begin
      e_ldg[e_ldi] = 1'b1;
      e_addr = ld_addr[e_ldi*AW +: AW];
    end
    if (e_sti >= 0) begin
      e_stg[e_sti] = 1'b1;
      e_we    = 1'b1;
      e_addr  = st_addr[e_sti*AW +: AW];
      e_wdata = st_data[e_sti*DW +: DW];
    end
  endtask

  task automatic model_commit();
    if (e_ldi >= 0) begin
      m_valid = 1;
      m_tag   = ld_tag[e_ldi*TW +: TW];
      m_data  = ref_mem[e_addr[7:0]];
    end else if (cdb_grant) begin
      m_valid = 0;
    end
    if (e_sti >= 0) ref_mem[e_addr[7:0]] = e_wdata;
    if (st_req == 0 || e_sti >= 0) m_starve = 0;
    else if (m_starve < SM) m_starve++;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    ld_req = '0; st_req = '0; cdb_grant = 1'b0;
    ld_addr = '0; ld_tag = '0; st_addr = '0; st_data = '0;
  endtask

  task automatic set_ld(input int i, input logic [AW-1:0] a, input logic [TW-1:0] t);
    ld_req[i] = 1'b1;
    ld_addr[i*AW +: AW] = a;
    ld_tag[i*TW +: TW] = t;
  endtask

  task automatic set_st(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    st_req[i] = 1'b1;
    st_addr[i*AW +: AW] = a;
    st_data[i*DW +: DW] = d;
  endtask

  task automatic drain();
    idle_inputs();
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    model_reset();
    #3;
    n_cmp++;
    if ({cdb_req, ld_grant, st_grant, mem_we, mem_addr, mem_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got req=%b lg=%b sg=%b we=%b a=%h wd=%h want all 0",
               cdb_req, ld_grant, st_grant, mem_we, mem_addr, mem_wdata);
    end
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      pre_we = 1'b1;
      pre_a  = 8'(a);
      pre_d  = (a == 'h10) ? 32'hDEADBEEF : $urandom;
      ref_mem[a] = pre_d;
    end
    @(negedge clk);
    pre_we = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load();
    set_ld(0, 32'h10, 4'd3);
    #2;
    n_cmp++;
    if (ld_grant !== 2'b01 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL load_grant: got lg=%b a=%h we=%b want 01/10/0", ld_grant, mem_addr, mem_we);
    end
    tick();
    idle_inputs();
    #2;
    n_cmp++;
    if (cdb_req !== 1'b1 || cdb_tag !== 4'd3 || cdb_data !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL load_cdb: got req=%b tag=%0d data=%h want 1/3/deadbeef", cdb_req, cdb_tag, cdb_data);
    end
    tick();
    #2;
    n_cmp++;
    if (cdb_req !== 1'b1 || cdb_tag !== 4'd3) begin
      n_err++;
      $display("FAIL load_hold: got req=%b tag=%0d want 1/3", cdb_req, cdb_tag);
    end
    drain();
    #2;
    n_cmp++;
    if (cdb_req !== 1'b0) begin
      n_err++;
      $display("FAIL load_drain: got req=%b want 0", cdb_req);
    end
  endtask

  task automatic test_store();
    set_st(1, 32'h20, 32'h12345678);
    #2;
    n_cmp++;
    if (st_grant !== 2'b10 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h12345678) begin
      n_err++;
      $display("FAIL store_grant: got sg=%b we=%b a=%h wd=%h want 10/1/20/12345678",
               st_grant, mem_we, mem_addr, mem_wdata);
    end
    tick();
    idle_inputs();
    set_ld(0, 32'h20, 4'd7);
    tick();
    idle_inputs();
    #2;
    n_cmp++;
    if (cdb_req !== 1'b1 || cdb_tag !== 4'd7 || cdb_data !== 32'h12345678) begin
      n_err++;
      $display("FAIL store_readback: got req=%b tag=%0d data=%h want 1/7/12345678", cdb_req, cdb_tag, cdb_data);
    end
    drain();
  endtask

  task automatic test_stall();
    set_ld(0, 32'h10, 4'd1);
    tick();
    idle_inputs();
    set_ld(0, 32'h30, 4'd2);
    set_ld(1, 32'h31, 4'd9);
    set_st(0, 32'h32, 32'hA5A5A5A5);
    #2;
    n_cmp++;
    if (ld_grant !== 2'b00 || st_grant !== 2'b01 || cdb_tag !== 4'd1) begin
      n_err++;
      $display("FAIL stall_store: got lg=%b sg=%b tag=%0d want 00/01/1", ld_grant, st_grant, cdb_tag);
    end
    tick();
    st_req = '0;
    cdb_grant = 1'b1;
    #2;
    n_cmp++;
    if (ld_grant !== 2'b01 || mem_addr !== 32'h30) begin
      n_err++;
      $display("FAIL stall_release: got lg=%b a=%h want 01/30", ld_grant, mem_addr);
    end
    tick();
    idle_inputs();
    #2;
    n_cmp++;
    if (cdb_req !== 1'b1 || cdb_tag !== 4'd2) begin
      n_err++;
      $display("FAIL stall_tag: got req=%b tag=%0d want 1/2", cdb_req, cdb_tag);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    set_ld(0, 32'h10, 4'd1);
    tick();
    idle_inputs();
    cdb_grant = 1'b1;
    set_ld(1, 32'h20, 4'd5);
    #2;
    n_cmp++;
    if (ld_grant !== 2'b10 || cdb_req !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_grant: got lg=%b req=%b want 10/1", ld_grant, cdb_req);
    end
    tick();
    idle_inputs();
    #2;
    n_cmp++;
    if (cdb_req !== 1'b1 || cdb_tag !== 4'd5 || cdb_data !== 32'h12345678) begin
      n_err++;
      $display("FAIL b2b_reload: got req=%b tag=%0d data=%h want 1/5/12345678", cdb_req, cdb_tag, cdb_data);
    end
    drain();
  endtask

  task automatic test_starve();
    bit exp_st;
    set_ld(0, 32'h40, 4'd4);
    set_st(0, 32'h44, 32'hCAFEF00D);
    cdb_grant = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #2;
`ifdef MSCHED_STARVE_GUARD_EN
      exp_st = (i == 3 || i == 7);
`else
      exp_st = 0;
`endif
      n_cmp++;
      if (st_grant !== (exp_st ? 2'b01 : 2'b00) || ld_grant !== (exp_st ? 2'b00 : 2'b01)) begin
        n_err++;
        $display("FAIL starve_cycle%0d: got sg=%b lg=%b want st=%0d", i + 1, st_grant, ld_grant, exp_st);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_async_reset();
    set_ld(0, 32'h10, 4'd6);
    tick();
    idle_inputs();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (cdb_req !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got req=%b want 0", cdb_req);
    end
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    set_ld(0, 32'h10, 4'd3);
    tick();
    idle_inputs();
    #2;
    n_cmp++;
    if (cdb_req !== 1'b1 || cdb_tag !== 4'd3 || cdb_data !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL post_reset_load: got req=%b tag=%0d data=%h want 1/3/deadbeef", cdb_req, cdb_tag, cdb_data);
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      ld_req    = NL'($urandom_range(0, 3));
      st_req    = ($urandom_range(0, 2) == 0) ? NS'($urandom_range(1, 3)) : '0;
      cdb_grant = $urandom_range(0, 1);
      for (int i = 0; i < NL; i++) begin
        ld_addr[i*AW +: AW] = 32'($urandom_range(0, 255));
        ld_tag[i*TW +: TW]  = TW'($urandom);
      end
      for (int i = 0; i < NS; i++) begin
        st_addr[i*AW +: AW] = 32'($urandom_range(0, 255));
        st_data[i*DW +: DW] = $urandom;
      end
      #2;
      model_eval();
      n_cmp++;
      if ({ld_grant, st_grant, mem_we, mem_addr, mem_wdata} !== {e_ldg, e_stg, e_we, e_addr, e_wdata}) begin
        n_err++;
        $display("FAIL rand_mem c%0d: got lg=%b sg=%b we=%b a=%h wd=%h want lg=%b sg=%b we=%b a=%h wd=%h",
                 c, ld_grant, st_grant, mem_we, mem_addr, mem_wdata, e_ldg, e_stg, e_we, e_addr, e_wdata);
      end
      n_cmp++;
      if (cdb_req !== m_valid || (m_valid && {cdb_tag, cdb_data} !== {m_tag, m_data})) begin
        n_err++;
        $display("FAIL rand_cdb c%0d: got req=%b tag=%0d data=%h want req=%b tag=%0d data=%h",
                 c, cdb_req, cdb_tag, cdb_data, m_valid, m_tag, m_data);
      end
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_stall();
    test_back_to_back();
    test_starve();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
